// File: rtl/csu_ctrl.sv
// Current-source array power sequencer and DAC code decoder (thermometer MSBs, binary LSBs).
// Define CSU_DWA_EN to rotate thermometer units with data-weighted averaging.
module csu_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        enable,
  input  logic        code_valid,
  input  logic [10:0] code,
  input  logic        red_sel,
  output logic        code_ready,
  input  logic [1:0]  atb_sel,
  output logic        pdb,
  output logic [1:0]  atb_ena,
  output logic [16:0] them_en,
  output logic [5:0]  bin_en,
  output logic        bin0_red_en,
  output logic        active
);

  typedef enum logic [1:0] {StOff, StPwrup, StActive, StDrain} state_e;

  localparam logic [10:0] CodeMax    = 11'd1087;
  localparam logic [7:0]  SettleInit = 8'(SETTLE_CYCLES);
  localparam logic [7:0]  DrainInit  = 8'd2;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pdb_q, pdb_d;
  logic        ready_q, ready_d;
  logic        active_q, active_d;
  logic [1:0]  atb_q, atb_d;
  logic [16:0] them_q, them_d;
  logic [5:0]  bin_q, bin_d;
  logic        red_q, red_d;

  logic        accept;
  logic [10:0] code_clamp;
  logic [4:0]  m_cnt;
  logic [5:0]  l_bits;
  logic [16:0] mask;
  logic [16:0] therm;

  // Deasserting enable wins over a simultaneous handshake.
  assign accept     = code_valid & ready_q & enable;
  assign code_clamp = (code > CodeMax) ? CodeMax : code;
  assign m_cnt      = code_clamp[10:6];
  assign l_bits     = code_clamp[5:0];
  assign mask       = (17'd1 << m_cnt) - 17'd1;

`ifdef CSU_DWA_EN
  logic [4:0]  ptr_q, ptr_d, ptr_adv;
  logic [5:0]  ptr_sum;
  logic [33:0] rot;

  // Rotate the m-unit run to start at the pointer, wrapping modulo 17.
  assign rot     = {17'd0, mask} << ptr_q;
  assign therm   = rot[16:0] | rot[33:17];
  assign ptr_sum = {1'b0, ptr_q} + {1'b0, m_cnt};
  assign ptr_adv = (ptr_sum >= 6'd17) ? 5'(ptr_sum - 6'd17) : ptr_sum[4:0];

  always_comb begin
    ptr_d = ptr_q;
    if (state_d == StOff) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d = ptr_adv;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign therm = mask;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= StOff;
      cnt_q    <= '0;
      pdb_q    <= 1'b0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
      atb_q    <= '0;
      them_q   <= '0;
      bin_q    <= '0;
      red_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pdb_q    <= pdb_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      atb_q    <= atb_d;
      them_q   <= them_d;
      bin_q    <= bin_d;
      red_q    <= red_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StOff: begin
        if (enable) begin
          state_d = StPwrup;
          cnt_d   = SettleInit;
        end
      end
      StPwrup: begin
        if (!enable) begin
          state_d = StOff;
          cnt_d   = '0;
        end else if (cnt_q <= 8'd1) begin
          state_d = StActive;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StActive: begin
        if (!enable) begin
          state_d = StDrain;
          cnt_d   = DrainInit;
        end
      end
      StDrain: begin
        if (cnt_q <= 8'd1) begin
          state_d = StOff;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = StOff;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    pdb_d    = (state_d != StOff);
    ready_d  = (state_d == StActive);
    active_d = (state_d == StActive);
    atb_d    = (state_d == StActive) ? atb_sel : 2'b00;
    them_d   = them_q;
    bin_d    = bin_q;
    red_d    = red_q;
    if (state_d != StActive) begin
      them_d = '0;
      bin_d  = '0;
      red_d  = 1'b0;
    end else if (accept) begin
      them_d = therm;
      bin_d  = red_sel ? {l_bits[5:1], 1'b0} : l_bits;
      red_d  = red_sel & l_bits[0];
    end
  end

  assign pdb         = pdb_q;
  assign code_ready  = ready_q;
  assign active      = active_q;
  assign atb_ena     = atb_q;
  assign them_en     = them_q;
  assign bin_en      = bin_q;
  assign bin0_red_en = red_q;

endmodule

// File: tb/tb_csu_ctrl.sv
// Bench for csu_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared each cycle against a behavioural model.
module tb_csu_ctrl;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        enable = 1'b0;
  logic        code_valid = 1'b0;
  logic [10:0] code = '0;
  logic        red_sel = 1'b0;
  logic [1:0]  atb_sel = '0;
  logic        code_ready;
  logic        pdb;
  logic [1:0]  atb_ena;
  logic [16:0] them_en;
  logic [5:0]  bin_en;
  logic        bin0_red_en;
  logic        active;

  csu_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .enable     (enable),
    .code_valid (code_valid),
    .code       (code),
    .red_sel    (red_sel),
    .code_ready (code_ready),
    .atb_sel    (atb_sel),
    .pdb        (pdb),
    .atb_ena    (atb_ena),
    .them_en    (them_en),
    .bin_en     (bin_en),
    .bin0_red_en(bin0_red_en),
    .active     (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
  endtask

  // Behavioural model: what each output must be, derived from the power sequence rules.
  logic        e_pdb, e_ready, e_active, e_red;
  logic [1:0]  e_atb;
  logic [16:0] e_them;
  logic [5:0]  e_bin;
  int          e_ptr, e_settle, e_drain;

  task automatic model_reset();
    e_pdb = 0; e_ready = 0; e_active = 0; e_red = 0;
    e_atb = 0; e_them = 0; e_bin = 0;
    e_ptr = 0; e_settle = 0; e_drain = 0;
  endtask

  task automatic model_step();
    int c, mm, l;
    logic [16:0] t;
    if (e_active) begin
      if (!enable) begin
        e_active = 0; e_ready = 0; e_drain = 2;
        e_atb = 0; e_them = 0; e_bin = 0; e_red = 0;
      end else begin
        if (code_valid) begin
          c  = (code > 11'd1087) ? 1087 : int'(code);
          mm = c / 64;
          l  = c % 64;
          t  = '0;
          for (int k = 0; k < mm; k++) t[(e_ptr + k) % 17] = 1'b1;
          e_them = t;
`ifdef CSU_DWA_EN
          e_ptr = (e_ptr + mm) % 17;
`endif
          e_bin = red_sel ? 6'(l - (l % 2)) : 6'(l);
          e_red = red_sel ? ((l % 2) == 1) : 1'b0;
        end
        e_atb = atb_sel;
      end
    end else if (e_drain > 0) begin
      e_drain--;
      if (e_drain == 0) begin
        e_pdb = 0; e_ptr = 0;
      end
    end else if (e_settle > 0) begin
      if (!enable) begin
        e_settle = 0; e_pdb = 0; e_ptr = 0;
      end else if (e_settle == 1) begin
        e_settle = 0; e_active = 1; e_ready = 1; e_atb = atb_sel;
      end else begin
        e_settle--;
      end
    end else if (enable) begin
      e_settle = SETTLE; e_pdb = 1;
    end
  endtask

  always @(posedge clk or negedge rstb) begin
    if (!rstb) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("outputs{pdb,rdy,act,atb,them,bin,red}",
        {3'b0, pdb, code_ready, active, atb_ena, them_en, bin_en, bin0_red_en},
        {3'b0, e_pdb, e_ready, e_active, e_atb, e_them, e_bin, e_red});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n;

  initial begin
    cyc(); cyc();
    chk("reset_outputs", 32'({pdb, code_ready, active, atb_ena, them_en, bin_en, bin0_red_en}), 0);
    rstb = 1'b1;
    cyc();

    // Power-up timing: enable in cycle 0, pdb in cycle 1, active in cycle 5.
    enable = 1'b1;
    cyc();
    chk("pwrup_pdb", 32'(pdb), 1);
    chk("pwrup_not_active", 32'(active), 0);
    cyc(); cyc(); cyc();
    chk("cycle4_not_active", 32'(active), 0);
    cyc();
    chk("cycle5_active", 32'(active), 1);
    chk("cycle5_ready", 32'(code_ready), 1);

    code_valid = 1'b1; code = 11'd677; red_sel = 1'b0;
    cyc();
    chk("c677_them", 32'(them_en), 32'h003FF);
    chk("c677_bin", 32'(bin_en), 32'h25);
    chk("c677_red", 32'(bin0_red_en), 0);
    chk("model_c677_them", 32'(e_them), 32'h003FF);
`ifdef CSU_DWA_EN
    cyc();
    chk("dwa_second_them", 32'(them_en), 32'h1FC07);
    chk("dwa_model_ptr", 32'(e_ptr), 3);
    code = 11'd2047;
`else
    code = 11'd2047;
    cyc();
    chk("c2047_them", 32'(them_en), 32'h0FFFF);
    chk("c2047_bin", 32'(bin_en), 32'h3F);
`endif
    red_sel = 1'b1; code = 11'd5;
    cyc();
    chk("red_bin", 32'(bin_en), 32'h04);
    chk("red_lsb", 32'(bin0_red_en), 1);
    chk("red_them", 32'(them_en), 0);

    code_valid = 1'b0; red_sel = 1'b0; atb_sel = 2'b10;
    cyc();
    chk("atb_active", 32'(atb_ena), 2);
    enable = 1'b0;
    cyc();
    chk("drain_atb", 32'(atb_ena), 0);
    chk("drain_them", 32'(them_en), 0);
    chk("drain_ready", 32'(code_ready), 0);
    chk("drain_pdb1", 32'(pdb), 1);
    cyc();
    chk("drain_pdb2", 32'(pdb), 1);
    cyc();
    chk("off_pdb", 32'(pdb), 0);

    // Reset mid power-up, then a fresh full settle count.
    enable = 1'b1;
    cyc(); cyc();
    chk("pwrup2_pdb", 32'(pdb), 1);
    #2 rstb = 1'b0;
    #1 chk("async_reset_outputs",
           32'({pdb, code_ready, active, atb_ena, them_en, bin_en, bin0_red_en}), 0);
    enable = 1'b0;
    #3 rstb = 1'b1;
    cyc();
    enable = 1'b1;
    n = 0;
    while (!active && n < 20) begin
      cyc();
      n++;
    end
    chk("restart_settle_len", 32'(n), 5);

    for (int i = 0; i < 3000; i++) begin
      if (!rstb) rstb = 1'b1;
      else if ($urandom_range(0, 199) == 0) rstb = 1'b0;
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      code_valid = 1'($urandom_range(0, 1));
      red_sel    = 1'($urandom_range(0, 1));
      atb_sel    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0:       code = 11'd1087;
        1:       code = 11'd1088;
        2:       code = 11'd2047;
        3:       code = 11'd0;
        4:       code = 11'($urandom_range(0, 63));
        default: code = 11'($urandom);
      endcase
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
